aq_djpeg_idctb_rdctl: RTL and testbench

- Read-side sequencer for the IDCT transpose buffer between the row and column IDCT passes.
- While the buffer reports a full bank (DataOutEnable), it issues the 32 read addresses of that bank and strobes the bank-advance read.
- It captures the 1-cycle-latency buffer data into a 2-entry skid FIFO and presents it to the column pass on a valid/ready handshake, with per-block index and last framing.

---
 rtl/aq_djpeg_idctb_rdctl.sv | 183 ++++++++++++++++++
 tb/tb_aq_djpeg_idctb_rdctl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_djpeg_idctb_rdctl.sv
// -----------------------------------------------------------------------------
// aq_djpeg_idctb_rdctl
//
// Read-side sequencer for the IDCT transpose buffer that sits between the row
// and column IDCT passes. When the buffer reports a complete bank, this block
// walks the 32 read addresses of that bank. The strobe on address 31 advances
// the buffer to its next bank. The buffer returns data one cycle after each
// address. That data is captured into a 2-entry skid FIFO and handed to the
// column pass on a valid/ready handshake, tagged with its index and a last
// flag.
//
// Ports:
//   clk            clock
//   rst            asynchronous active-low reset
//   DataInit       synchronous abort/clear of the current block (shared with
//                  the buffer); highest priority
//   DataOutEnable  buffer has at least one complete bank readable
//   DataOutRead    read strobe to the buffer (combinational)
//   DataOutAddress buffer read address (always the address register)
//   DataOutA/B     buffer lanes, valid one cycle after the address
//   OutValid       skid head valid
//   OutReady       column pass accepts the head
//   OutA/B         head data lanes
//   OutIndex       buffer address the head was read from
//   OutLast        head is index 31
//   Busy           sequencing, a read in flight, or the skid is non-empty
// -----------------------------------------------------------------------------
module aq_djpeg_idctb_rdctl #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          DataInit,
  input  logic          DataOutEnable,
  output logic          DataOutRead,
  output logic [4:0]    DataOutAddress,
  input  logic [DW-1:0] DataOutA,
  input  logic [DW-1:0] DataOutB,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [DW-1:0] OutA,
  output logic [DW-1:0] OutB,
  output logic [4:0]    OutIndex,
  output logic          OutLast,
  output logic          Busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_READ = 1'b1;

  logic [0:0]    r_state;
  logic [4:0]    r_addr;
  logic          r_inflight;
  logic [4:0]    r_inflight_idx;

  // Skid FIFO: slot "head" drives the outputs, slot "tail" holds the second
  // entry. r_count is the number of valid entries (0..2).
  logic [1:0]    r_count;
  logic [DW-1:0] r_head_a;
  logic [DW-1:0] r_head_b;
  logic [4:0]    r_head_idx;
  logic [DW-1:0] r_tail_a;
  logic [DW-1:0] r_tail_b;
  logic [4:0]    r_tail_idx;

  logic          w_pop;
  logic          w_push;
  logic [2:0]    w_occupancy;
  logic          w_credit_ok;
  logic          w_issue;

  assign w_pop  = OutValid && OutReady;
  assign w_push = r_inflight;

  // Entries the skid will hold after this cycle if nothing new is issued.
  // A new read is allowed only if its data still has a free slot when it
  // arrives next cycle. This keeps the skid from overflowing and still allows
  // one read per cycle when the consumer keeps up.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_credit_ok = (w_occupancy < 3'd2);
  assign w_issue     = (r_state == S_READ) && w_credit_ok && !DataInit;

  assign DataOutRead    = w_issue;
  assign DataOutAddress = r_addr;

  assign OutValid = (r_count != 2'd0);
  assign OutA     = r_head_a;
  assign OutB     = r_head_b;
  assign OutIndex = r_head_idx;
  // Gate OutLast with OutValid so that a stale head left after a flush does
  // not report itself as last.
  assign OutLast  = OutValid && (r_head_idx == 5'd31);
  assign Busy     = (r_state != S_IDLE) || r_inflight || (r_count != 2'd0);

  // Sequencer: address walk and the in-flight tracker for the 1-cycle read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_addr         <= 5'd0;
      r_inflight     <= 1'b0;
      r_inflight_idx <= 5'd0;
    end else if (DataInit) begin
      r_state    <= S_IDLE;
      r_addr     <= 5'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_idx <= r_addr;
      end
      if (r_state == S_IDLE) begin
        // IDLE is always entered one cycle after the addr-31 strobe. The
        // enable seen here therefore already reflects the advanced bank.
        if (DataOutEnable) begin
          r_state <= S_READ;
          r_addr  <= 5'd0;
        end
      end else begin
        if (w_issue) begin
          r_addr <= r_addr + 5'd1;  // 31 wraps to 0 naturally
          if (r_addr == 5'd31) begin
            r_state <= S_IDLE;
          end
        end
      end
    end
  end

  // Skid FIFO. Credit gating guarantees that a push never meets a full FIFO
  // unless a pop happens in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= 2'd0;
      r_head_a   <= '0;
      r_head_b   <= '0;
      r_head_idx <= 5'd0;
      r_tail_a   <= '0;
      r_tail_b   <= '0;
      r_tail_idx <= 5'd0;
    end else if (DataInit) begin
      // The in-flight entry is dropped: w_push is not honoured here.
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head_a   <= DataOutA;
            r_head_b   <= DataOutB;
            r_head_idx <= r_inflight_idx;
          end else begin
            r_tail_a   <= DataOutA;
            r_tail_b   <= DataOutB;
            r_tail_idx <= r_inflight_idx;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head_a   <= r_tail_a;
          r_head_b   <= r_tail_b;
          r_head_idx <= r_tail_idx;
          r_count    <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_head_a   <= r_tail_a;
            r_head_b   <= r_tail_b;
            r_head_idx <= r_tail_idx;
            r_tail_a   <= DataOutA;
            r_tail_b   <= DataOutB;
            r_tail_idx <= r_inflight_idx;
          end else begin
            r_head_a   <= DataOutA;
            r_head_b   <= DataOutB;
            r_head_idx <= r_inflight_idx;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aq_djpeg_idctb_rdctl.sv
// -----------------------------------------------------------------------------
// Testbench for aq_djpeg_idctb_rdctl.
// The transpose buffer is modelled as a bank counter. Each bank k holds
// A = 0x1000 + 64*k + addr and B = 0x2000 + 64*k + addr. The expected output
// stream is a queue of (bank, index) pairs, and 32 pairs are pushed whenever
// the bench makes a bank readable.
// -----------------------------------------------------------------------------
module tb_aq_djpeg_idctb_rdctl;

  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          DataInit;
  logic          DataOutEnable;
  logic          DataOutRead;
  logic [4:0]    DataOutAddress;
  logic [DW-1:0] DataOutA;
  logic [DW-1:0] DataOutB;
  logic          OutValid;
  logic          OutReady;
  logic [DW-1:0] OutA;
  logic [DW-1:0] OutB;
  logic [4:0]    OutIndex;
  logic          OutLast;
  logic          Busy;

  aq_djpeg_idctb_rdctl #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .DataInit(DataInit), .DataOutEnable(DataOutEnable),
    .DataOutRead(DataOutRead), .DataOutAddress(DataOutAddress),
    .DataOutA(DataOutA), .DataOutB(DataOutB),
    .OutValid(OutValid), .OutReady(OutReady), .OutA(OutA), .OutB(OutB),
    .OutIndex(OutIndex), .OutLast(OutLast), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int bank;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   wr_bank = 0;   // banks made readable (written by the stimulus)
  int   rd_bank = 0;   // banks consumed (written by the buffer model)
  int   issued = 0;
  int   accepted = 0;
  int   accept_total = 0;

  function automatic logic [15:0] fa(input int b, input int idx);
    return 16'h1000 + 16'(b * 64) + 16'(idx);
  endfunction

  function automatic logic [15:0] fb(input int b, input int idx);
    return 16'h2000 + 16'(b * 64) + 16'(idx);
  endfunction

  // Buffer model: data one cycle after the address, and the bank advances on
  // the addr-31 strobe. DataInit and reset discard whatever is buffered.
  assign DataOutEnable = (wr_bank != rd_bank);
  always @(posedge clk) begin
    if (!rst || DataInit)
      rd_bank <= wr_bank;
    else if (DataOutRead && DataOutAddress == 5'd31)
      rd_bank <= rd_bank + 1;
    DataOutA <= fa(rd_bank, int'(DataOutAddress));
    DataOutB <= fb(rd_bank, int'(DataOutAddress));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic add_bank();
    for (int i = 0; i < 32; i++) exp_q.push_back('{bank: wr_bank, idx: i});
    wr_bank++;
  endtask

  // One clock cycle: drive inputs at the falling edge, then sample 1ns later.
  // Every accepted output is compared against the scoreboard, and the number
  // of reads outstanding beyond the accepted outputs must never exceed 2.
  task automatic step(input bit rdy, input bit init);
    exp_t e;
    @(negedge clk);
    OutReady = rdy;
    DataInit = init;
    #1;
    if (rst) begin
      if (DataOutRead) issued++;
      if (OutValid && OutReady) begin
        accepted++;
        accept_total++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", {27'b0, OutIndex}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          $display("out bank=%0d idx=%0d a=%h b=%h last=%0d", e.bank, OutIndex, OutA, OutB, OutLast);
          check("out_idx", {27'b0, OutIndex}, 32'(e.idx));
          check("out_a", {16'b0, OutA}, {16'b0, fa(e.bank, e.idx)});
          check("out_b", {16'b0, OutB}, {16'b0, fb(e.bank, e.idx)});
          check("out_last", {31'b0, OutLast}, {31'b0, (e.idx == 31)});
        end
      end
      check("outstanding_le2", {31'b0, ((issued - accepted) <= 2)}, 32'd1);
      if (init) begin
        check("init_no_read", {31'b0, DataOutRead}, 32'd0);
        exp_q.delete();
        issued = 0;
        accepted = 0;
      end
    end
  endtask

  task automatic drain(input bit random_ready, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || Busy) && n < budget) begin
      step(random_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("drain_busy", {31'b0, Busy}, 32'd0);
  endtask

  task automatic wait_first_read(input string tag, input int budget);
    int n;
    n = 0;
    while (!DataOutRead && n < budget) begin
      step(1'b1, 1'b0);
      n++;
    end
    check({tag, "_strobe"}, {31'b0, DataOutRead}, 32'd1);
    check({tag, "_addr0"}, {27'b0, DataOutAddress}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'b0, OutValid}, 32'd0);
    check({tag, "_read"}, {31'b0, DataOutRead}, 32'd0);
    check({tag, "_addr"}, {27'b0, DataOutAddress}, 32'd0);
    check({tag, "_busy"}, {31'b0, Busy}, 32'd0);
    check({tag, "_a"}, {16'b0, OutA}, 32'd0);
    check({tag, "_b"}, {16'b0, OutB}, 32'd0);
    check({tag, "_idx"}, {27'b0, OutIndex}, 32'd0);
    check({tag, "_last"}, {31'b0, OutLast}, 32'd0);
  endtask

  initial begin
    int k;
    int n;
    int last31;
    int gap_seen;
    int acc0;
    int bank_id;
    logic [4:0] frozen;

    rst = 1'b0;
    OutReady = 1'b0;
    DataInit = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    check_reset_outputs("reset");
    rst = 1'b1;
    step(1'b1, 1'b0);

    // Single block, ready held high. Cycle 0 is the cycle where enable rises.
    add_bank();
    for (k = 1; k <= 36; k++) begin
      step(1'b1, 1'b0);
      check("sb_read", {31'b0, DataOutRead}, {31'b0, (k >= 1 && k <= 32)});
      if (k >= 1 && k <= 32) check("sb_addr", {27'b0, DataOutAddress}, 32'(k - 1));
      check("sb_valid", {31'b0, OutValid}, {31'b0, (k >= 3 && k <= 34)});
      if (k >= 3 && k <= 34) begin
        check("sb_idx", {27'b0, OutIndex}, 32'(k - 3));
        check("sb_last", {31'b0, OutLast}, {31'b0, (k == 34)});
      end
    end
    drain(1'b0, 20);

    // Back-to-back blocks: one idle cycle between the addr-31 and addr-0 strobes.
    add_bank();
    add_bank();
    acc0 = accept_total;
    last31 = -1;
    gap_seen = 0;
    k = 0;
    while ((exp_q.size() != 0 || Busy) && k < 200) begin
      step(1'b1, 1'b0);
      k++;
      if (DataOutRead && DataOutAddress == 5'd31) begin
        last31 = k;
      end else if (DataOutRead && DataOutAddress == 5'd0 && last31 >= 0) begin
        check("b2b_gap", 32'(k - last31), 32'd2);
        gap_seen = 1;
      end
    end
    check("b2b_gap_seen", 32'(gap_seen), 32'd1);
    check("b2b_count", 32'(accept_total - acc0), 32'd64);
    drain(1'b0, 10);

    // Backpressure: output index 3 is held at the head for 5 cycles.
    add_bank();
    bank_id = wr_bank - 1;
    for (k = 1; k <= 5; k++) step(1'b1, 1'b0);
    frozen = 5'd5;
    for (k = 6; k <= 10; k++) begin
      step(1'b0, 1'b0);
      check("bp_valid", {31'b0, OutValid}, 32'd1);
      check("bp_head_idx", {27'b0, OutIndex}, 32'd3);
      check("bp_head_a", {16'b0, OutA}, {16'b0, fa(bank_id, 3)});
      check("bp_head_b", {16'b0, OutB}, {16'b0, fb(bank_id, 3)});
      check("bp_no_read", {31'b0, DataOutRead}, 32'd0);
      check("bp_addr_frozen", {27'b0, DataOutAddress}, {27'b0, frozen});
    end
    drain(1'b0, 100);

    // Random ready over 4 blocks.
    acc0 = accept_total;
    for (int b = 0; b < 4; b++) add_bank();
    drain(1'b1, 2000);
    check("rand_count", 32'(accept_total - acc0), 32'd128);

    // DataInit while the skid is full with index 10 at the head.
    add_bank();
    for (k = 1; k <= 12; k++) step(1'b1, 1'b0);
    for (k = 13; k <= 15; k++) step(1'b0, 1'b0);
    check("init_head_idx", {27'b0, OutIndex}, 32'd10);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("init_valid", {31'b0, OutValid}, 32'd0);
    check("init_busy", {31'b0, Busy}, 32'd0);
    check("init_read", {31'b0, DataOutRead}, 32'd0);
    add_bank();
    wait_first_read("init_restart", 10);
    drain(1'b0, 100);

    // Asynchronous reset in the middle of a block.
    add_bank();
    n = 0;
    while (!(DataOutRead && DataOutAddress == 5'd17) && n < 100) begin
      step(1'b1, 1'b0);
      n++;
    end
    check("rst_at_17", {27'b0, DataOutAddress}, 32'd17);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    issued = 0;
    accepted = 0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    rst = 1'b1;
    add_bank();
    wait_first_read("rst_restart", 10);
    drain(1'b0, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
